watch_ctrl: RTL and testbench

Sequencing controller for the stopwatch seconds counter.
- Debounces and edge-detects two raw push-buttons: start/stop and lap/reset.
- Runs the run/pause/lap/clear state machine and gates the 1 s tick into counter enables.
- Captures lap values and drives the value shown on the LEDs.
- Sits between the board buttons, the 1 s pulse generator, the counter and the LED driver.

---
 rtl/watch_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_watch_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/watch_ctrl.sv
// Stopwatch sequencing controller: debounces two buttons, runs IDLE/RUN/PAUSE/LAP, gates 1 s ticks, drives the display.
// Latency: button edge -> event DEBOUNCE_CYCLES+3 cycles, state one more edge; cnt_en/cnt_clr/disp are registered (1 cycle).
// Backpressure: none; all inputs are sampled every cycle. Optional macro WATCH_SATURATE_EN enables stop-at-all-ones.
module watch_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int COUNT_W         = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_ss,
  input  logic               btn_lr,
  input  logic               pulse_1s,
  input  logic [COUNT_W-1:0] count,
  output logic               cnt_en,
  output logic               cnt_clr,
  output logic [COUNT_W-1:0] disp,
  output logic [1:0]         state,
  output logic               sat
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } state_t;

  // Debounce counter must hold values up to DEBOUNCE_CYCLES-1.
  localparam int DCW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [DCW-1:0] DMAX = DCW'(DEBOUNCE_CYCLES - 1);

  // Bit 0 is start/stop, bit 1 is lap/reset.
  logic [1:0]         raw;
  logic [1:0]         sync1;
  logic [1:0]         sync2;
  logic [1:0]         deb;
  logic [1:0]         deb_q;
  logic [1:0]         ev;
  logic [DCW-1:0]     dcnt [2];

  logic               ev_ss;
  logic               ev_lr;

  state_t             st_q;
  state_t             st_d;
  logic               en_d;
  logic               clr_d;
  logic               lap_ld;
  logic               sat_set;
  logic               sat_q;
  logic               ss_ok;
  logic [COUNT_W-1:0] lap_reg;

  assign raw   = {btn_lr, btn_ss};
  assign ev_ss = ev[0];
  assign ev_lr = ev[1];
  assign state = st_q;
  assign sat   = sat_q;

  // Synchronize, debounce and rising-edge detect both buttons.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_q <= '0;
      ev    <= '0;
      for (int i = 0; i < 2; i++) begin
        dcnt[i] <= '0;
      end
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_q <= deb;
      // Only a press (0->1 of the filtered level) is an event; release is silent.
      ev    <= deb & ~deb_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] != deb[i]) begin
          if (dcnt[i] == DMAX) begin
            deb[i]  <= sync2[i];
            dcnt[i] <= '0;
          end else begin
            dcnt[i] <= dcnt[i] + DCW'(1);
          end
        end else begin
          dcnt[i] <= '0;
        end
      end
    end
  end

  // Next-state, enable, clear and lap-capture decode.
  always_comb begin
    st_d    = st_q;
    clr_d   = 1'b0;
    lap_ld  = 1'b0;
    sat_set = 1'b0;
    // Enable follows the pre-transition state so a tick on the leaving edge still counts.
    en_d    = ((st_q == RUN) || (st_q == LAP)) && pulse_1s;
    // A saturated, paused watch only leaves through lap/reset.
    ss_ok   = ev_ss && !sat_q;

    case (st_q)
      IDLE: begin
        if (ss_ok) begin
          st_d = RUN;
        end else if (ev_lr) begin
          clr_d = 1'b1;
        end
      end
      RUN: begin
        if (ss_ok) begin
          st_d = PAUSE;
        end else if (ev_lr) begin
          st_d   = LAP;
          lap_ld = 1'b1;
        end
      end
      LAP: begin
        if (ss_ok) begin
          st_d = PAUSE;
        end else if (ev_lr) begin
          st_d = RUN;
        end
      end
      PAUSE: begin
        if (ss_ok) begin
          st_d = RUN;
        end else if (ev_lr) begin
          st_d  = IDLE;
          clr_d = 1'b1;
        end
      end
      default: begin
        st_d = IDLE;
      end
    endcase

`ifdef WATCH_SATURATE_EN
    // Counter at all-ones while running: stop counting and park in PAUSE.
    if (((st_q == RUN) || (st_q == LAP)) && (count == {COUNT_W{1'b1}})) begin
      en_d    = 1'b0;
      st_d    = PAUSE;
      lap_ld  = 1'b0;
      sat_set = 1'b1;
    end
`endif

    // The clear cycle never carries an increment.
    if (clr_d) begin
      en_d = 1'b0;
    end
  end

  // State, counter strobes, lap register and display registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q    <= IDLE;
      cnt_en  <= 1'b0;
      cnt_clr <= 1'b0;
      disp    <= '0;
      lap_reg <= '0;
    end else begin
      st_q    <= st_d;
      cnt_en  <= en_d;
      cnt_clr <= clr_d;
      disp    <= (st_q == LAP) ? lap_reg : count;
      if (lap_ld) begin
        lap_reg <= count;
      end
    end
  end

`ifdef WATCH_SATURATE_EN
  // Saturation flag: set on reaching all-ones, cleared together with the counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_q <= 1'b0;
    end else if (clr_d) begin
      sat_q <= 1'b0;
    end else if (sat_set) begin
      sat_q <= 1'b1;
    end
  end
`else
  assign sat_q = 1'b0;
`endif

endmodule

// File: tb/tb_watch_ctrl.sv
// Directed bench for watch_ctrl with a short debounce window.
// Inputs are driven 1 ns after the rising edge, outputs sampled there too.
// Summary line reports comparisons made and mismatches found.
module tb_watch_ctrl;

  localparam int DEB = 4;
  localparam int CW  = 8;

  logic          clk;
  logic          rst;
  logic          btn_ss;
  logic          btn_lr;
  logic          pulse_1s;
  logic [CW-1:0] count;
  logic          cnt_en;
  logic          cnt_clr;
  logic [CW-1:0] disp;
  logic [1:0]    state;
  logic          sat;

  int n_cmp;
  int n_bad;

  watch_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .COUNT_W        (CW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .btn_ss  (btn_ss),
    .btn_lr  (btn_lr),
    .pulse_1s(pulse_1s),
    .count   (count),
    .cnt_en  (cnt_en),
    .cnt_clr (cnt_clr),
    .disp    (disp),
    .state   (state),
    .sat     (sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Press one or both buttons: state changes on the 8th edge, then release and let the filter settle.
  task automatic press(input bit ss, input bit lr, output int clrs, output int ens);
    clrs = 0;
    ens  = 0;
    btn_ss = ss;
    btn_lr = lr;
    for (int i = 0; i < 18; i++) begin
      if (i == 10) begin
        btn_ss = 1'b0;
        btn_lr = 1'b0;
      end
      tick();
      if (cnt_clr) clrs++;
      if (cnt_en) ens++;
    end
  endtask

  initial begin
    int clrs;
    int ens;
    n_cmp    = 0;
    n_bad    = 0;
    rst      = 1'b1;
    btn_ss   = 1'b0;
    btn_lr   = 1'b0;
    pulse_1s = 1'b0;
    count    = '0;

    // 1. Reset values and a too-short glitch.
    repeat (3) tick();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_en", 32'(cnt_en), 32'd0);
    chk("rst_clr", 32'(cnt_clr), 32'd0);
    chk("rst_disp", 32'(disp), 32'd0);
    chk("rst_sat", 32'(sat), 32'd0);
    rst = 1'b0;
    tick();
    btn_ss = 1'b1;
    repeat (3) tick();
    btn_ss = 1'b0;
    repeat (15) tick();
    chk("glitch_state", 32'(state), 32'd0);

    // 2. Exact press latency, tick gating, pause.
    btn_ss = 1'b1;
    repeat (7) tick();
    chk("lat_pre", 32'(state), 32'd0);
    tick();
    chk("lat_run", 32'(state), 32'd1);
    repeat (2) tick();
    btn_ss = 1'b0;
    repeat (10) tick();
    ens = 0;
    for (int t = 0; t < 3; t++) begin
      pulse_1s = 1'b1;
      tick();
      if (cnt_en) ens++;
      pulse_1s = 1'b0;
      for (int c = 0; c < 19; c++) begin
        tick();
        if (cnt_en) ens++;
      end
      count = count + 8'd1;
    end
    chk("run_ticks", 32'(ens), 32'd3);
    press(1'b1, 1'b0, clrs, ens);
    chk("pause_state", 32'(state), 32'd2);
    pulse_1s = 1'b1;
    tick();
    pulse_1s = 1'b0;
    chk("pause_no_en", 32'(cnt_en), 32'd0);

    // 3. Lap freezes the display while counting continues.
    press(1'b1, 1'b0, clrs, ens);
    chk("resume_run", 32'(state), 32'd1);
    count = 8'd37;
    tick();
    press(1'b0, 1'b1, clrs, ens);
    chk("lap_state", 32'(state), 32'd3);
    chk("lap_disp", 32'(disp), 32'd37);
    count = 8'd38;
    pulse_1s = 1'b1;
    tick();
    pulse_1s = 1'b0;
    chk("lap_en", 32'(cnt_en), 32'd1);
    count = 8'd40;
    repeat (3) tick();
    chk("lap_frozen", 32'(disp), 32'd37);
    press(1'b0, 1'b1, clrs, ens);
    chk("unlap_state", 32'(state), 32'd1);
    chk("unlap_disp", 32'(disp), 32'd40);

    // 4. Clearing from PAUSE and from IDLE.
    press(1'b1, 1'b0, clrs, ens);
    chk("pause2", 32'(state), 32'd2);
    press(1'b0, 1'b1, clrs, ens);
    chk("clr_pause_cnt", 32'(clrs), 32'd1);
    chk("clr_pause_st", 32'(state), 32'd0);
    chk("clr_pause_en", 32'(ens), 32'd0);
    press(1'b0, 1'b1, clrs, ens);
    chk("clr_idle_cnt", 32'(clrs), 32'd1);
    chk("clr_idle_st", 32'(state), 32'd0);

    // 5. Simultaneous presses, then reset in the middle of a debounce.
    press(1'b1, 1'b0, clrs, ens);
    chk("run3", 32'(state), 32'd1);
    press(1'b1, 1'b1, clrs, ens);
    chk("both_state", 32'(state), 32'd2);
    chk("both_disp", 32'(disp), 32'd40);
    btn_ss = 1'b1;
    repeat (4) tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_state", 32'(state), 32'd0);
    chk("mid_rst_disp", 32'(disp), 32'd0);
    chk("mid_rst_en", 32'(cnt_en), 32'd0);
    chk("mid_rst_clr", 32'(cnt_clr), 32'd0);
    btn_ss = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    repeat (15) tick();
    chk("post_rst_state", 32'(state), 32'd0);

    // 6. Running into all-ones.
    press(1'b1, 1'b0, clrs, ens);
    chk("run4", 32'(state), 32'd1);
    count = 8'hFE;
    tick();
    count = 8'hFF;
    pulse_1s = 1'b1;
    tick();
    pulse_1s = 1'b0;
`ifdef WATCH_SATURATE_EN
    chk("sat_en", 32'(cnt_en), 32'd0);
    chk("sat_state", 32'(state), 32'd2);
    chk("sat_flag", 32'(sat), 32'd1);
    press(1'b1, 1'b0, clrs, ens);
    chk("sat_ss_ignored", 32'(state), 32'd2);
    press(1'b0, 1'b1, clrs, ens);
    chk("sat_clr_cnt", 32'(clrs), 32'd1);
    chk("sat_clr_state", 32'(state), 32'd0);
    chk("sat_cleared", 32'(sat), 32'd0);
`else
    chk("wrap_en", 32'(cnt_en), 32'd1);
    chk("wrap_state", 32'(state), 32'd1);
    chk("wrap_sat", 32'(sat), 32'd0);
    count = 8'h00;
    tick();
    tick();
    chk("wrap_run", 32'(state), 32'd1);
    chk("wrap_disp", 32'(disp), 32'd0);
    chk("wrap_sat2", 32'(sat), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected completion");
    $fatal(1);
  end

endmodule
